// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg : shared constants and payload sizing for the MEM->WB commit stage
// ----------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
  localparam int          ZERO_REG         = 0;

  // Stored bits: pc, result, wreg, regwrite, plus hilo_write and {HI,LO} when present.
  function automatic int payload_w(input int data_w, input int reg_aw, input bit hilo_en);
    return 2*data_w + reg_aw + 1 + (hilo_en ? (2*data_w + 1) : 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_skid_buf.sv
// ----------------------------------------------------------------------------
// wb_skid_buf : 2-entry valid/ready skid buffer over a flat payload, with flush
// ----------------------------------------------------------------------------
`default_nettype none

module wb_skid_buf #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         accept;

  // in_ready depends only on state, so upstream sees no combinational path.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & ~skid_valid_q & ~flush;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (~main_valid_q | out_ready) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_commit_stage.sv
// ----------------------------------------------------------------------------
// wb_commit_stage : MEM->WB register with skid handshake, r0 gating, retire count
// ----------------------------------------------------------------------------
`default_nettype none

module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter bit                HILO_EN  = 1'b1,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT),
  parameter int                CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [REG_AW-1:0]   in_wreg,
  input  logic                in_regwrite,
  input  logic                in_hilo_write,
  input  logic [2*DATA_W-1:0] in_hilo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_pc,
  output logic [DATA_W-1:0]   out_result,
  output logic [REG_AW-1:0]   out_wreg,
  output logic                out_regwrite,
  output logic                out_hilo_write,
  output logic [2*DATA_W-1:0] out_hilo,
  output logic [CNT_W-1:0]    retire_cnt
);

  localparam int             PW            = payload_w(DATA_W, REG_AW, HILO_EN);
  localparam int             BW            = 2*DATA_W + REG_AW + 1;
  localparam logic [PW-1:0]  RESET_PAYLOAD = {RESET_PC, {(PW-DATA_W){1'b0}}};

  logic [PW-1:0]       in_payload, held_payload;
  logic [DATA_W-1:0]   held_pc, held_result;
  logic [REG_AW-1:0]   held_wreg;
  logic                held_rw, held_hw;
  logic [2*DATA_W-1:0] held_hilo;
  logic [CNT_W-1:0]    retire_q, retire_d;

  assign {held_pc, held_result, held_wreg, held_rw} = held_payload[PW-1 -: BW];

  generate
    if (HILO_EN) begin : g_hilo
      assign in_payload = {in_pc, in_result, in_wreg, in_regwrite, in_hilo_write, in_hilo};
      assign held_hw    = held_payload[2*DATA_W];
      assign held_hilo  = held_payload[2*DATA_W-1:0];
    end else begin : g_no_hilo
      logic unused_hilo;
      assign unused_hilo = ^{in_hilo_write, in_hilo};
      assign in_payload  = {in_pc, in_result, in_wreg, in_regwrite};
      assign held_hw     = 1'b0;
      assign held_hilo   = '0;
    end
  endgenerate

  wb_skid_buf #(
    .W         (PW),
    .RESET_VAL (RESET_PAYLOAD)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held_payload)
  );

  assign out_pc         = held_pc;
  assign out_result     = held_result;
  assign out_wreg       = held_wreg;
  // Register 0 is hard-wired; the payload still flows for tracing.
  assign out_regwrite   = out_valid & held_rw & (held_wreg != REG_AW'(ZERO_REG));
  assign out_hilo_write = out_valid & held_hw;
  assign out_hilo       = held_hilo;
  assign retire_cnt     = retire_q;

  always_comb begin
    retire_d = retire_q;
    if (out_valid & out_ready) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_commit_stage : scoreboard bench for wb_commit_stage (full and no-HI/LO builds)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_commit_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        rw;
    logic        hw;
    logic [63:0] hilo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_result = '0;
  logic [4:0]  in_wreg = '0;
  logic        in_regwrite = 1'b0, in_hilo_write = 1'b0;
  logic [63:0] in_hilo = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_result;
  logic [4:0]  out_wreg;
  logic        out_regwrite, out_hilo_write;
  logic [63:0] out_hilo;
  logic [31:0] retire_cnt;

  logic        b_flush = 1'b0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_pc = '0;
  logic        b_out_valid;
  logic [31:0] b_out_pc, b_out_result;
  logic [4:0]  b_out_wreg;
  logic        b_out_regwrite, b_out_hilo_write;
  logic [63:0] b_out_hilo;
  logic [3:0]  b_retire_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [31:0] sb2[$];

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_wreg(in_wreg),
    .in_regwrite(in_regwrite), .in_hilo_write(in_hilo_write), .in_hilo(in_hilo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_wreg(out_wreg),
    .out_regwrite(out_regwrite), .out_hilo_write(out_hilo_write), .out_hilo(out_hilo),
    .retire_cnt(retire_cnt)
  );

  wb_commit_stage #(.HILO_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_result(32'h0000_0042), .in_wreg(5'd3),
    .in_regwrite(1'b1), .in_hilo_write(1'b1), .in_hilo(64'h1234),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_pc(b_out_pc), .out_result(b_out_result), .out_wreg(b_out_wreg),
    .out_regwrite(b_out_regwrite), .out_hilo_write(b_out_hilo_write), .out_hilo(b_out_hilo),
    .retire_cnt(b_retire_cnt)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  // Offer one payload; the expected record is queued once acceptance is certain.
  task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wr,
                      input logic rw, input logic hw, input logic [63:0] hl,
                      input logic exp_rw, input bit must_ready);
    in_valid = 1'b1; in_pc = pc; in_result = res; in_wreg = wr;
    in_regwrite = rw; in_hilo_write = hw; in_hilo = hl;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (must_ready && k == 0) check("stream_in_ready", in_ready, 1);
      if (in_ready) begin
        sb.push_back('{pc: pc, result: res, wreg: wr, rw: exp_rw, hw: hw, hilo: hl});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    fail_msg("send_timeout");
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); @(posedge clk); #1;
    if (sb.size() != 0) fail_msg("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) begin
        check("idle_regwrite", out_regwrite, 0);
        check("idle_hilo_write", out_hilo_write, 0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_result", out_result, e.result);
          check("out_wreg", out_wreg, e.wreg);
          check("out_regwrite", out_regwrite, e.rw);
          check("out_hilo_write", out_hilo_write, e.hw);
          check("out_hilo", out_hilo, e.hilo);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid) begin
      if (sb2.size() == 0) begin
        errors++; checks++;
        $display("FAIL b_unexpected_out: got pc %h expected no output", b_out_pc);
      end else begin
        check("b_out_pc", b_out_pc, sb2.pop_front());
        check("b_out_hilo_write", b_out_hilo_write, 0);
        check("b_out_hilo", b_out_hilo, 0);
        check("b_out_regwrite", b_out_regwrite, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a live input that must be ignored.
    in_valid = 1'b1; in_pc = 32'h1111_1111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_pc", out_pc, 32'hbfc00000);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_hilo", out_hilo, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Streaming: 8 back-to-back with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h400 + 32'(4*i), 32'h1111_1111 * i, 5'(i), 1'b1, i[0],
           {32'(i), ~32'(i)}, (i != 0), 1'b1);
    end
    in_valid = 1'b0;
    drain();
    check("stream_retire", retire_cnt, 8);

    // Stall: two held, third waits for the skid to drain.
    out_ready = 1'b0;
    send(32'h600, 32'hA, 5'd1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    send(32'h604, 32'hB, 5'd2, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_pc", out_pc, 32'h600);
    @(posedge clk); #1;
    fork
      send(32'h608, 32'hC, 5'd3, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    in_valid = 1'b0;
    drain();
    check("stall_retire", retire_cnt, 11);

    // Register-0 gating.
    send(32'h500, 32'hdeadbeef, 5'd0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    send(32'h504, 32'h12345678, 5'd5, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
    check("r0_retire", retire_cnt, 13);

    // Flush with both entries full, input offered, and an output completing.
    out_ready = 1'b0;
    send(32'h700, 32'hD, 5'd4, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    send(32'h704, 32'hE, 5'd4, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    in_valid = 1'b1; in_pc = 32'h708; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush1_out_valid", out_valid, 0);
    check("flush1_in_ready", in_ready, 1);
    check("flush1_retire", retire_cnt, 14);
    @(posedge clk); #1;

    // Flush while stalled: nothing retires.
    out_ready = 1'b0;
    send(32'h800, 32'hF, 5'd6, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush2_out_valid", out_valid, 0);
    check("flush2_retire", retire_cnt, 14);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h900, 32'h9, 5'd7, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();
    check("post_flush_retire", retire_cnt, 15);

    // No-HI/LO build with a 4-bit counter: 17 retires wrap to 1.
    for (int i = 0; i < 17; i++) begin
      b_in_valid = 1'b1; b_in_pc = 32'hA00 + 32'(4*i);
      @(negedge clk);
      if (b_in_ready) sb2.push_back(32'hA00 + 32'(4*i));
      else check("b_in_ready", b_in_ready, 1);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("b_retire_wrap", b_retire_cnt, 1);

    check("sb_empty", sb.size(), 0);
    check("sb2_empty", sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
